// File: rtl/md_force_pkg.sv
// Shared types for the reference-particle force writeback path.
// ID layout, force bundle and writeback FSM states.
package md_force_pkg;

    localparam int DEF_DATA_WIDTH        = 32;
    localparam int DEF_PARTICLE_ID_WIDTH = 20;
    localparam int DEF_CELL_ID_WIDTH     = 3;

    typedef enum logic [DEF_CELL_ID_WIDTH-1:0] {
        CELL_1 = 3'd1,
        CELL_2 = 3'd2,
        CELL_3 = 3'd3
    } cell_e;

    typedef struct packed {
        logic [2:0][DEF_CELL_ID_WIDTH-1:0] cell_id;
        logic [DEF_PARTICLE_ID_WIDTH-1:0]  particle;
    } full_id_t;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] x;
        logic [DEF_DATA_WIDTH-1:0] y;
        logic [DEF_DATA_WIDTH-1:0] z;
    } force_vec_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } wb_state_e;

endpackage

// File: rtl/ref_force_fifo.sv
// Per-channel synchronous FIFO for accumulated force entries.
// Push and pop may coincide; a push while full is ignored unless popping.
module ref_force_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    // pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push}
                           - {{AW{1'b0}}, do_pop};
        end
    end

    // storage, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/ref_force_wb_collector.sv
// Collects per-channel accumulated forces, drops empty ones and
// serialises survivors round-robin into the force cache write port.
module ref_force_wb_collector
    import md_force_pkg::*;
#(
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int PARTICLE_ID_WIDTH = DEF_PARTICLE_ID_WIDTH,
    parameter int CELL_ID_WIDTH     = DEF_CELL_ID_WIDTH,
    parameter int ID_WIDTH          = 3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH,
    parameter int NUM_ACC           = 7,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_ACC-1:0]            in_acc_valid,
    input  logic [NUM_ACC*ID_WIDTH-1:0]   in_acc_id,
    input  logic [NUM_ACC*DATA_WIDTH-1:0] in_acc_force_x,
    input  logic [NUM_ACC*DATA_WIDTH-1:0] in_acc_force_y,
    input  logic [NUM_ACC*DATA_WIDTH-1:0] in_acc_force_z,
    input  logic [NUM_ACC-1:0]            in_start_wb,
    output logic                          out_wb_valid,
    input  logic                          out_wb_ready,
    output logic [$clog2(NUM_ACC)-1:0]    out_wb_acc_idx,
    output logic [ID_WIDTH-1:0]           out_wb_id,
    output logic [DATA_WIDTH-1:0]         out_wb_force_x,
    output logic [DATA_WIDTH-1:0]         out_wb_force_y,
    output logic [DATA_WIDTH-1:0]         out_wb_force_z,
    output logic                          out_wb_done,
    output logic                          out_overflow
);

    localparam int EW = ID_WIDTH + 3*DATA_WIDTH;
    localparam int IW = $clog2(NUM_ACC);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]         rst_sync;
    logic               rst_int_n;
    logic [NUM_ACC-1:0] qual;
    logic [NUM_ACC-1:0] pop;
    logic [NUM_ACC-1:0] full;
    logic [NUM_ACC-1:0] empty;
    logic [NUM_ACC-1:0] occ;
    logic [EW-1:0]      fifo_rdata [NUM_ACC];
    logic [NUM_ACC-1:0] req;
    logic [NUM_ACC-1:0] hi_mask;
    logic [NUM_ACC-1:0] pick_src;
    logic [IW-1:0]      gnt_idx;
    logic [IW-1:0]      last_gnt;
    logic               found;
    logic               load;
    logic               drain_pending;
    logic               clr_pending;
    wb_state_e          state;
    wb_state_e          state_n;

    // async assert, synchronised release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    for (genvar i = 0; i < NUM_ACC; i++) begin : g_ch
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] fx;
        logic [DATA_WIDTH-1:0] fy;
        logic [DATA_WIDTH-1:0] fz;
        logic [CW-1:0]         cnt;

        assign id = in_acc_id[i*ID_WIDTH +: ID_WIDTH];
        assign fx = in_acc_force_x[i*DATA_WIDTH +: DATA_WIDTH];
        assign fy = in_acc_force_y[i*DATA_WIDTH +: DATA_WIDTH];
        assign fz = in_acc_force_z[i*DATA_WIDTH +: DATA_WIDTH];

        // -0.0 is a real contribution, so compare raw bits
        assign qual[i] = in_acc_valid[i]
                      && (id[PARTICLE_ID_WIDTH-1:0] != '0)
                      && ({fx, fy, fz} != '0);
        assign occ[i]  = (cnt != '0);

        ref_force_fifo #(
            .WIDTH (EW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_int_n),
            .push  (qual[i]),
            .wdata ({id, fx, fy, fz}),
            .pop   (pop[i]),
            .rdata (fifo_rdata[i]),
            .count (cnt),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    // rotating-priority arbiter and output-register load
    always_comb begin
        req      = ~empty;
        hi_mask  = '0;
        for (int j = 0; j < NUM_ACC; j++) begin
            hi_mask[j] = (j > int'(last_gnt));
        end
        pick_src = ((req & hi_mask) != '0) ? (req & hi_mask) : req;
        gnt_idx  = '0;
        found    = 1'b0;
        for (int j = 0; j < NUM_ACC; j++) begin
            if (!found && pick_src[j]) begin
                gnt_idx = IW'(j);
                found   = 1'b1;
            end
        end
        load = (state == DRAIN) && found
            && (!out_wb_valid || out_wb_ready);
        pop  = '0;
        if (load) pop[gnt_idx] = 1'b1;
    end

    // next state; round ends once nothing is stored, arriving or held
    always_comb begin
        state_n     = state;
        clr_pending = 1'b0;
        unique case (state)
            COLLECT: begin
                if (drain_pending) begin
                    state_n     = DRAIN;
                    clr_pending = 1'b1;
                end
            end
            DRAIN: begin
                if (occ == '0 && qual == '0 && !load
                    && (!out_wb_valid || out_wb_ready))
                    state_n = DONE;
            end
            DONE:    state_n = COLLECT;
            default: state_n = COLLECT;
        endcase
    end

    assign out_wb_done = (state == DONE);

    // state, pending request and sticky overflow
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state         <= COLLECT;
            drain_pending <= 1'b0;
            out_overflow  <= 1'b0;
        end else begin
            state         <= state_n;
            drain_pending <= (drain_pending && !clr_pending)
                          || (in_start_wb != '0);
            if ((qual & full & ~pop) != '0) out_overflow <= 1'b1;
        end
    end

    // output register, held stable until accepted
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            out_wb_valid   <= 1'b0;
            out_wb_acc_idx <= '0;
            out_wb_id      <= '0;
            out_wb_force_x <= '0;
            out_wb_force_y <= '0;
            out_wb_force_z <= '0;
            last_gnt       <= IW'(NUM_ACC-1);
        end else if (load) begin
            out_wb_valid   <= 1'b1;
            out_wb_acc_idx <= gnt_idx;
            last_gnt       <= gnt_idx;
            {out_wb_id, out_wb_force_x, out_wb_force_y,
             out_wb_force_z} <= fifo_rdata[gnt_idx];
        end else if (out_wb_valid && out_wb_ready) begin
            out_wb_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ref_force_wb_collector.sv
// Directed and randomised checks of the force writeback collector
// against a queue-based reference model.
module tb_ref_force_wb_collector;

    localparam int N     = 7;
    localparam int DW    = 32;
    localparam int PW    = 20;
    localparam int IDW   = 29;
    localparam int DEPTH = 4;
    localparam int EW    = IDW + 3*DW;

    typedef logic [EW-1:0] ent_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    in_acc_valid = '0;
    logic [N*IDW-1:0] in_acc_id = '0;
    logic [N*DW-1:0] in_fx = '0;
    logic [N*DW-1:0] in_fy = '0;
    logic [N*DW-1:0] in_fz = '0;
    logic [N-1:0]    in_start_wb = '0;
    logic            out_wb_valid;
    logic            out_wb_ready = 1'b0;
    logic [2:0]      out_wb_acc_idx;
    logic [IDW-1:0]  out_wb_id;
    logic [DW-1:0]   ox;
    logic [DW-1:0]   oy;
    logic [DW-1:0]   oz;
    logic            out_wb_done;
    logic            out_overflow;

    always #5 clk = ~clk;

    ref_force_wb_collector dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_acc_valid   (in_acc_valid),
        .in_acc_id      (in_acc_id),
        .in_acc_force_x (in_fx),
        .in_acc_force_y (in_fy),
        .in_acc_force_z (in_fz),
        .in_start_wb    (in_start_wb),
        .out_wb_valid   (out_wb_valid),
        .out_wb_ready   (out_wb_ready),
        .out_wb_acc_idx (out_wb_acc_idx),
        .out_wb_id      (out_wb_id),
        .out_wb_force_x (ox),
        .out_wb_force_y (oy),
        .out_wb_force_z (oz),
        .out_wb_done    (out_wb_done),
        .out_overflow   (out_overflow)
    );

    ent_t mq [N][$];
    int   m_last;
    bit   m_ovf;
    int   ncmp = 0;
    int   nfail = 0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) mq[c].delete();
        m_last = N-1;
        m_ovf  = 1'b0;
    endtask

    task automatic clear_in();
        in_acc_valid = '0;
        in_start_wb  = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_in();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        model_reset();
    endtask

    // an entry counts only with a nonzero particle and any nonzero bit
    task automatic set_ch(input int ch, input logic [IDW-1:0] id,
                          input logic [DW-1:0] x, input logic [DW-1:0] y,
                          input logic [DW-1:0] z);
        in_acc_valid[ch]          = 1'b1;
        in_acc_id[ch*IDW +: IDW]  = id;
        in_fx[ch*DW +: DW]        = x;
        in_fy[ch*DW +: DW]        = y;
        in_fz[ch*DW +: DW]        = z;
        if (id[PW-1:0] != 0 && {x, y, z} != 0) begin
            if (mq[ch].size() >= DEPTH) m_ovf = 1'b1;
            else mq[ch].push_back({id, x, y, z});
        end
    endtask

    task automatic send(input int ch, input logic [IDW-1:0] id,
                        input logic [DW-1:0] x, input logic [DW-1:0] y,
                        input logic [DW-1:0] z);
        set_ch(ch, id, x, y, z);
        tick();
        clear_in();
    endtask

    task automatic pulse_wb(input int ch);
        in_start_wb[ch] = 1'b1;
        tick();
        in_start_wb = '0;
    endtask

    function automatic logic [IDW-1:0] nz_id();
        logic [IDW-1:0] v;
        v = IDW'($urandom());
        if (v[PW-1:0] == 0) v[0] = 1'b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] nz_f();
        return $urandom() | 32'h1;
    endfunction

    function automatic logic [IDW-1:0] r_id();
        logic [IDW-1:0] v;
        v = IDW'($urandom());
        if ($urandom_range(0, 5) == 0) v[PW-1:0] = '0;
        return v;
    endfunction

    function automatic logic [DW-1:0] r_f();
        return ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom();
    endfunction

    // next nonempty channel after the last one served
    function automatic int m_pick();
        for (int k = 1; k <= N; k++) begin
            if (mq[(m_last + k) % N].size() > 0) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!out_wb_valid && k < 20) begin
            tick();
            k++;
        end
        chk(tag, out_wb_valid, 1);
    endtask

    // serve one drain round, checking each transfer, until done
    task automatic drain(input bit rnd, output int ntx,
                         output int first_tx, output int last_tx,
                         output int done_cyc);
        int  cyc;
        int  c;
        bit  got;
        ent_t e;
        cyc = 0;
        got = 1'b0;
        ntx = 0;
        first_tx = -1;
        last_tx  = -1;
        done_cyc = -1;
        while (!got && cyc < 300) begin
            tick();
            cyc++;
            if (out_wb_done) begin
                got      = 1'b1;
                done_cyc = cyc;
            end else begin
                out_wb_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_wb_valid && out_wb_ready) begin
                    c = m_pick();
                    if (c < 0) begin
                        chk("wb_extra", out_wb_valid, 0);
                    end else begin
                        e = mq[c].pop_front();
                        chk("wb_idx", out_wb_acc_idx, c);
                        chk("wb_data", {out_wb_id, ox, oy, oz}, e);
                        m_last = c;
                    end
                    if (first_tx < 0) first_tx = cyc;
                    last_tx = cyc;
                    ntx++;
                end
            end
        end
        out_wb_ready = 1'b1;
        chk("done_seen", got, 1);
        c = 0;
        for (int k = 0; k < N; k++) c += mq[k].size();
        chk("left_undrained", c, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ntx, f, l, d, c;
        ent_t e;
        logic [IDW-1:0] id;

        // reset state
        apply_reset();
        chk("rst_valid", out_wb_valid, 0);
        chk("rst_done", out_wb_done, 0);
        chk("rst_ovf", out_overflow, 0);
        chk("rst_idx", out_wb_acc_idx, 0);
        chk("rst_data", {out_wb_id, ox, oy, oz}, 0);

        // filtering: zero particle, all-zero force, -0.0
        set_ch(2, {9'h053, 20'd0}, 32'h3F800000, 0, 0);
        set_ch(3, {9'h053, 20'd5}, 0, 0, 0);
        set_ch(4, {9'h053, 20'd5}, 32'h80000000, 0, 0);
        tick();
        clear_in();
        out_wb_ready = 1'b1;
        pulse_wb(0);
        drain(0, ntx, f, l, d);
        chk("filt_count", ntx, 1);
        chk("filt_ovf", out_overflow, 0);

        // overflow: five entries into a four-deep FIFO
        for (int i = 0; i < 5; i++) send(1, nz_id(), nz_f(), r_f(), r_f());
        tick();
        chk("ovf_flag", out_overflow, m_ovf);
        pulse_wb(5);
        drain(0, ntx, f, l, d);
        chk("ovf_count", ntx, DEPTH);
        chk("ovf_sticky", out_overflow, 1);

        // reset in the middle of a drain
        for (int i = 0; i < 3; i++) send(1, nz_id(), nz_f(), 0, 0);
        out_wb_ready = 1'b0;
        pulse_wb(1);
        wait_valid("mid_valid");
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_wb_valid, 0);
        chk("mid_rst_done", out_wb_done, 0);
        chk("mid_rst_ovf", out_overflow, 0);
        chk("mid_rst_data", {out_wb_acc_idx, out_wb_id, ox, oy, oz}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        model_reset();
        out_wb_ready = 1'b1;
        pulse_wb(0);
        drain(0, ntx, f, l, d);
        chk("mid_rst_empty", ntx, 0);

        // round robin over channels 0, 3 and 6
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            set_ch(0, nz_id(), nz_f(), r_f(), r_f());
            set_ch(3, nz_id(), r_f(), nz_f(), r_f());
            set_ch(6, nz_id(), r_f(), r_f(), nz_f());
            tick();
            clear_in();
        end
        out_wb_ready = 1'b1;
        pulse_wb(3);
        drain(0, ntx, f, l, d);
        chk("rr_count", ntx, 6);
        chk("rr_rate", l - f, 5);
        chk("rr_done_gap", d - l, 1);

        // backpressure: held request stays stable
        send(2, nz_id(), nz_f(), nz_f(), nz_f());
        send(5, nz_id(), nz_f(), nz_f(), nz_f());
        out_wb_ready = 1'b0;
        pulse_wb(2);
        wait_valid("bp_valid");
        c = m_pick();
        e = mq[c][0];
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", out_wb_valid, 1);
            chk("bp_hold_data", {out_wb_acc_idx, out_wb_id, ox, oy, oz},
                {3'(c), e});
            tick();
        end
        drain(0, ntx, f, l, d);
        chk("bp_count", ntx, 2);

        // start_wb during a drain triggers a follow-up round
        send(0, nz_id(), nz_f(), 0, 0);
        send(0, nz_id(), nz_f(), 0, 0);
        out_wb_ready = 1'b0;
        pulse_wb(0);
        wait_valid("late_valid");
        pulse_wb(3);
        drain(0, ntx, f, l, d);
        chk("late_r1_count", ntx, 2);
        id = nz_id();
        send(2, id, 0, 0, nz_f());
        drain(0, ntx, f, l, d);
        chk("late_r2_count", ntx, 1);
        chk("late_r2_prompt", (f > 0 && f <= 3), 1);

        // randomised rounds with random backpressure
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < int'($urandom_range(1, 7)); k++) begin
                for (int ch = 0; ch < N; ch++) begin
                    if ($urandom_range(0, 2) == 0)
                        set_ch(ch, r_id(), r_f(), r_f(), r_f());
                end
                tick();
                clear_in();
            end
            pulse_wb(int'($urandom_range(0, N-1)));
            drain(1, ntx, f, l, d);
            chk("rnd_ovf", out_overflow, m_ovf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
